branch_predict_unit: RTL
========================

Name: branch_predict_unit

Overview:
- Branch resolution and prediction block for the pipelined MIPS core; successor to the single-cycle BEQ/BNE branch-select logic.
- Fetch side: a 2-bit saturating-counter branch history table (BHT) indexed by PC predicts taken/not-taken.
- Execute side: resolves six branch conditions, detects mispredicts, produces the redirect PC and flush, updates the BHT, and keeps saturating branch/mispredict statistics.

Parameters:
- DATA_WIDTH, 32, operand width for condition evaluation.
- PC_WIDTH, 32, program counter width.
- BHT_ENTRIES, 16, number of 2-bit counters; power of two, minimum 2.
- CNT_INIT, 2'b01, reset value of every BHT counter (weakly not-taken).
- STAT_WIDTH, 16, width of statistics counters.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_pc  in  PC_WIDTH  fetch-stage PC.
- if_predict_taken  out  1  BHT prediction for if_pc; combinational read.
- ex_valid  in  1  EX stage holds a valid instruction.
- ex_stall  in  1  EX stage stalled; suppresses all state updates.
- ex_branch_op  in  3  0 none, 1 BEQ, 2 BNE, 3 BLEZ, 4 BGTZ, 5 BLTZ, 6 BGEZ, 7 reserved (treated as none).
- ex_rs_data  in  DATA_WIDTH  rs operand.
- ex_rt_data  in  DATA_WIDTH  rt operand.
- ex_pc  in  PC_WIDTH  PC of the EX-stage instruction.
- ex_pc_plus4  in  PC_WIDTH  fall-through address.
- ex_target  in  PC_WIDTH  computed branch target.
- ex_pred_taken  in  1  prediction piped from fetch.
- ex_taken  out  1  resolved outcome.
- mispredict  out  1  flush IF/ID and redirect fetch.
- redirect_pc  out  PC_WIDTH  ex_target if ex_taken, else ex_pc_plus4.
- branch_count  out  STAT_WIDTH  resolved branches, saturating.
- mispredict_count  out  STAT_WIDTH  mispredicts, saturating.

Behaviour:
- **Index:** IDX_BITS = log2(BHT_ENTRIES); index = pc[IDX_BITS+1:2]. Word-aligned; bits [1:0] are ignored.
- **Prediction:** if_predict_taken = counter[index(if_pc)][1]. The read is combinational from registered state.
- **Conditions (signed, two's complement):**
  - BEQ: rs==rt.
  - BNE: rs!=rt.
  - BLEZ: rs<=0.
  - BGTZ: rs>0.
  - BLTZ: rs<0.
  - BGEZ: rs>=0.
  - rt is ignored for ops 3–6.
- **is_branch** = ex_valid & op in 1..6.
- **ex_taken** = is_branch & cond. Forced to 0 when not is_branch.
- **mispredict** = is_branch & (ex_taken != ex_pred_taken). It is combinational in the EX cycle, so the flush happens in the same cycle.
- **redirect_pc:** always driven per the mux rule; only meaningful when mispredict=1.
- **BHT update:** on the rising clk edge where is_branch & ~ex_stall, the counter at index(ex_pc) is updated.
  - Taken: increment, saturating at 3.
  - Not taken: decrement, saturating at 0.
  - One update per cycle. The new value is visible to if_predict_taken on the following cycle.
- **Read/update collision (same index, same cycle):** if_predict_taken returns the old value; there is no bypass.
- **Statistics:** on the same edge and qualifier, branch_count += 1; mispredict_count += 1 if mispredict. Both saturate at all-ones and never wrap.
- **Stall:** when ex_stall=1, there are no BHT or statistics updates. Combinational outputs still reflect their inputs.
- **Reset:** asynchronous, takes effect immediately.
  - All counters go to CNT_INIT and both statistics go to 0.
  - Outputs during reset: if_predict_taken = CNT_INIT[1] (0 by default); ex_taken, mispredict, redirect_pc follow their inputs combinationally.
  - A reset asserted mid-update discards that update.
- **Reserved op 7:** treated as a non-branch; produces no flush and no update.

Decomposition:
- **Shared package `mips_branch_pkg`:** branch op encodings (BR_NONE..BR_BGEZ), the 2-bit counter constants (SNT=0, WNT=1, WT=2, ST=3), and a saturating next-state function.
- **Sub-module `bht_2bit`:** one natural sub-module holding the counter array. It has a combinational read port, a synchronous update port, and asynchronous reset.
- **Top level:** condition evaluation, mispredict/redirect logic and statistics.

Test Plan:
- **Reset and fall-through:** assert reset, then release. Expect if_predict_taken=0 for any PC and both counts 0. BEQ rs=5 rt=5 with pred=0 → ex_taken=1, mispredict=1, redirect_pc=ex_target, branch_count=1, mispredict_count=1.
- **Training:** three taken BNE at ex_pc=0x40 (rs=1, rt=2). Counter goes 1→2→3; if_pc=0x40 predicts taken from the cycle after the first update. Then two not-taken → counter 1, predict 0.
- **Signed conditions:** rs=0x80000000 → BLTZ taken, BGEZ not taken, BLEZ taken, BGTZ not taken. rs=0 → BLEZ taken, BGEZ taken, BGTZ not taken.
- **Aliasing and collision:** with BHT_ENTRIES=16, PCs 0x00 and 0x40 share index 0. Update 0x00 while fetching 0x40 in the same cycle → old prediction returned; new value seen next cycle.
- **Stall, non-branch and reserved op:** hold ex_stall=1 for 3 cycles on a taken BEQ → counters and stats unchanged. Repeat with ex_valid=0, and separately with op=7 → no update and mispredict=0.
- **Saturation and mid-operation reset:** STAT_WIDTH=4, run 20 mispredicts → both counts hold at 15. Assert reset between clock edges → counts 0 and BHT at CNT_INIT immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mips_branch_pkg.sv
// Shared definitions for MIPS branch resolution and prediction: op encodings,
// 2-bit counter states and the saturating counter update.
package mips_branch_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLEZ = 3'd3,
        BR_BGTZ = 3'd4,
        BR_BLTZ = 3'd5,
        BR_BGEZ = 3'd6,
        BR_RSVD = 3'd7
    } br_op_e;

    localparam logic [1:0] SNT = 2'd0;
    localparam logic [1:0] WNT = 2'd1;
    localparam logic [1:0] WT  = 2'd2;
    localparam logic [1:0] ST  = 2'd3;

    function automatic logic [1:0] satNext(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != ST) nxt = ctr + 2'd1;
        end else begin
            if (ctr != SNT) nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters with a combinational read
// port and a single synchronous update port.
module bht_2bit
    import mips_branch_pkg::*;
#(
    parameter int         ENTRIES  = 16,
    parameter int         IDX_BITS = $clog2(ENTRIES),
    parameter logic [1:0] CNT_INIT = WNT
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [IDX_BITS-1:0] rdIdx_i,
    output logic                rdTaken_o,
    input  logic                updEn_i,
    input  logic [IDX_BITS-1:0] updIdx_i,
    input  logic                updTaken_i
);

    logic [1:0] ctr_q [ENTRIES];
    logic [1:0] ctr_d [ENTRIES];

    // Read straight from the registered array, so a same-cycle update is not bypassed.
    assign rdTaken_o = ctr_q[rdIdx_i][1];

    always_comb begin
        ctr_d = ctr_q;
        if (updEn_i) begin
            ctr_d[updIdx_i] = satNext(ctr_q[updIdx_i], updTaken_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CNT_INIT;
            end
        end else begin
            ctr_q <= ctr_d;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// EX-stage branch resolution, mispredict/redirect generation, BHT training and
// saturating branch statistics; fetch-side prediction comes from bht_2bit.
module branch_predict_unit
    import mips_branch_pkg::*;
#(
    parameter int         DATA_WIDTH  = 32,
    parameter int         PC_WIDTH    = 32,
    parameter int         BHT_ENTRIES = 16,
    parameter logic [1:0] CNT_INIT    = 2'b01,
    parameter int         STAT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PC_WIDTH-1:0]   if_pc,
    output logic                  if_predict_taken,
    input  logic                  ex_valid,
    input  logic                  ex_stall,
    input  logic [2:0]            ex_branch_op,
    input  logic [DATA_WIDTH-1:0] ex_rs_data,
    input  logic [DATA_WIDTH-1:0] ex_rt_data,
    input  logic [PC_WIDTH-1:0]   ex_pc,
    input  logic [PC_WIDTH-1:0]   ex_pc_plus4,
    input  logic [PC_WIDTH-1:0]   ex_target,
    input  logic                  ex_pred_taken,
    output logic                  ex_taken,
    output logic                  mispredict,
    output logic [PC_WIDTH-1:0]   redirect_pc,
    output logic [STAT_WIDTH-1:0] branch_count,
    output logic [STAT_WIDTH-1:0] mispredict_count
);

    localparam int IDX_BITS = $clog2(BHT_ENTRIES);

    logic                  isBranch;
    logic                  cond;
    logic                  rsNeg;
    logic                  rsZero;
    logic                  updEn;
    logic                  unusedPcBits;
    logic [STAT_WIDTH-1:0] branchCnt_q, branchCnt_d;
    logic [STAT_WIDTH-1:0] mispCnt_q, mispCnt_d;

    assign rsNeg  = ex_rs_data[DATA_WIDTH-1];
    assign rsZero = (ex_rs_data == '0);

    // Signed compares against zero reduce to sign bit and zero detect.
    always_comb begin
        cond     = 1'b0;
        isBranch = 1'b0;
        case (br_op_e'(ex_branch_op))
            BR_BEQ:  begin isBranch = 1'b1; cond = (ex_rs_data == ex_rt_data); end
            BR_BNE:  begin isBranch = 1'b1; cond = (ex_rs_data != ex_rt_data); end
            BR_BLEZ: begin isBranch = 1'b1; cond = rsNeg | rsZero;             end
            BR_BGTZ: begin isBranch = 1'b1; cond = ~rsNeg & ~rsZero;           end
            BR_BLTZ: begin isBranch = 1'b1; cond = rsNeg;                      end
            BR_BGEZ: begin isBranch = 1'b1; cond = ~rsNeg;                     end
            default: begin isBranch = 1'b0; cond = 1'b0;                       end
        endcase
        isBranch = isBranch & ex_valid;
    end

    assign ex_taken    = isBranch & cond;
    assign mispredict  = isBranch & (ex_taken != ex_pred_taken);
    assign redirect_pc = ex_taken ? ex_target : ex_pc_plus4;
    assign updEn       = isBranch & ~ex_stall;

    assign unusedPcBits = ^{if_pc, ex_pc};

    bht_2bit #(
        .ENTRIES  (BHT_ENTRIES),
        .IDX_BITS (IDX_BITS),
        .CNT_INIT (CNT_INIT)
    ) uBht (
        .clk_i      (clk),
        .rst_i      (reset),
        .rdIdx_i    (if_pc[IDX_BITS+1:2]),
        .rdTaken_o  (if_predict_taken),
        .updEn_i    (updEn),
        .updIdx_i   (ex_pc[IDX_BITS+1:2]),
        .updTaken_i (ex_taken)
    );

    // Statistics hold at all-ones rather than wrapping.
    always_comb begin
        branchCnt_d = branchCnt_q;
        mispCnt_d   = mispCnt_q;
        if (updEn) begin
            if (~&branchCnt_q) branchCnt_d = branchCnt_q + STAT_WIDTH'(1);
            if (mispredict && ~&mispCnt_q) mispCnt_d = mispCnt_q + STAT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branchCnt_q <= '0;
            mispCnt_q   <= '0;
        end else begin
            branchCnt_q <= branchCnt_d;
            mispCnt_q   <= mispCnt_d;
        end
    end

    assign branch_count     = branchCnt_q;
    assign mispredict_count = mispCnt_q;

endmodule
